// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM states and byte-lane mask helper shared by the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, ISSUE, LOAD_CAP, RMW_MERGE, RESP} lsu_state_e;
  // off is already aligned to the access size, so a halfword shifts by 0 or 2
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    return f3[1:0] == 2'b00 ? 4'b0001 << off : f3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load lane extract/extend and sub-word store merge into a read word
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [3:0]  mask_i,
  input  logic [31:0] rdata_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);
  logic        is_b, is_h, sx;
  logic [15:0] sh;
  logic [31:0] lanes, wrep;
  // extract and extend the addressed lane; replicate store data and splice it in under the mask
  always_comb begin
    is_b    = funct3_i == F3_B || funct3_i == F3_BU;
    is_h    = funct3_i == F3_H || funct3_i == F3_HU;
    sx      = funct3_i == F3_B || funct3_i == F3_H;
    sh      = 16'(rdata_i >> {off_i, 3'b000});
    load_o  = is_b ? {{24{sx & sh[7]}}, sh[7:0]} : is_h ? {{16{sx & sh[15]}}, sh} : rdata_i;
    lanes   = {{8{mask_i[3]}}, {8{mask_i[2]}}, {8{mask_i[1]}}, {8{mask_i[0]}}};
    wrep    = is_b ? {4{wdata_i[7:0]}} : {2{wdata_i}};
    merge_o = (rdata_i & ~lanes) | (wrep & lanes);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte-addressed loads/stores onto a word-only data memory (LSU_MISALIGN_TRAP_EN traps misaligned accesses)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter logic [31:0] RESET_RDATA = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_write_data,
  output logic                  mem_memwrite,
  output logic                  mem_memread,
  output logic [3:0]            mem_sign_mask,
  input  logic [31:0]           mem_read_data
);
  lsu_state_e            state_q;
  logic                  we_q, valid_q, err_q, rd_q, wr_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q, off_d;
  logic [31:0]           wdata_q, rdata_q, load_data, merge_data;
  logic [ADDR_WIDTH-1:0] maddr_q;
  logic [3:0]            mask_q;
  logic                  is_w, is_h, bad_f3, err_d;
  // classify the incoming request; without the trap, misaligned low bits are simply dropped
  always_comb begin
    is_w   = req_funct3[1:0] == 2'b10;
    is_h   = req_funct3[1:0] == 2'b01;
    bad_f3 = req_we ? req_funct3 > F3_W : req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11;
`ifdef LSU_MISALIGN_TRAP_EN
    err_d  = bad_f3 || (is_h && req_addr[0]) || (is_w && req_addr[1:0] != 2'b00);
`else
    err_d  = bad_f3;
`endif
    off_d  = is_w ? 2'b00 : is_h ? {req_addr[1], 1'b0} : req_addr[1:0];
  end
  // access sequencer with registered strobes and response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      mask_q  <= '0;
      rdata_q <= RESET_RDATA;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          off_q   <= off_d;
          wdata_q <= req_wdata;
          maddr_q <= {2'b00, req_addr[ADDR_WIDTH-1:2]};
          mask_q  <= lane_mask(req_funct3, off_d);
          state_q <= err_d ? RESP : ISSUE;
          valid_q <= err_d;
          err_q   <= err_d;
          rd_q    <= !err_d && !(req_we && is_w);
          wr_q    <= !err_d && req_we && is_w;
        end
        ISSUE: begin
          state_q <= !we_q ? LOAD_CAP : f3_q == F3_W ? RESP : RMW_MERGE;
          wr_q    <= we_q && f3_q != F3_W;
          valid_q <= we_q && f3_q == F3_W;
        end
        LOAD_CAP: begin
          rdata_q <= load_data;
          state_q <= RESP;
          valid_q <= 1'b1;
        end
        RMW_MERGE: begin
          state_q <= RESP;
          valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  lsu_align u_align (
    .funct3_i(f3_q),
    .off_i   (off_q),
    .mask_i  (mask_q),
    .rdata_i (mem_read_data),
    .wdata_i (wdata_q[15:0]),
    .load_o  (load_data),
    .merge_o (merge_data)
  );
  // strobes are masked by reset so an access cut off by reset cannot write at the reset edge
  assign req_ready      = state_q == IDLE;
  assign resp_valid     = valid_q;
  assign resp_err       = err_q;
  assign resp_rdata     = rdata_q;
  assign mem_addr       = maddr_q;
  assign mem_sign_mask  = mask_q;
  assign mem_memread    = rd_q & ~reset;
  assign mem_memwrite   = wr_q & ~reset;
  assign mem_write_data = state_q == RMW_MERGE ? merge_data : wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against a byte-level memory model
module tb_load_store_unit;
  localparam logic [31:0] RESET_RDATA = 32'h0;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err, mem_memwrite, mem_memread;
  logic [31:0] resp_rdata, mem_addr, mem_write_data;
  logic [31:0] mem_read_data = 32'h0;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem [16384];
  logic [31:0] model_mem [int];
  logic [31:0] model_rdata = RESET_RDATA, held = RESET_RDATA, exp_rdata = RESET_RDATA;
  logic        exp_err = 1'b0;
  logic        pre_en = 1'b0;
  int          pre_idx = 0;
  logic [31:0] pre_val = 32'h0;
  int          errors = 0, checks = 0;
  logic [31:0] got;
  logic        got_err;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_memwrite) mem[int'(mem_addr % 32'd16384)] <= mem_write_data;
    if (mem_memread) mem_read_data <= mem[int'(mem_addr % 32'd16384)];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset) held = RESET_RDATA;
    else begin
      if (mem_memread || mem_memwrite) chk("strobe_excl", 32'(mem_memread & mem_memwrite), 32'h0);
      if (resp_valid) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        held = exp_rdata;
      end else begin
        chk("rdata_hold", resp_rdata, held);
        chk("err_idle", 32'(resp_err), 32'h0);
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] val);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk); #1 pre_en = 1'b0;
    model_mem[idx] = val;
  endtask

  task automatic wait_ready();
    logic ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      ok = req_ready;
    end
    chk("ready_timeout", 32'(ok), 32'h1);
  endtask

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] r, output logic re);
    int sz, off, w, lat, nrd, nwr, e_lat, e_rd, e_wr;
    logic bad, err, done;
    logic [31:0] old, nw, v, seen_wd;
    logic [3:0] e_mask;
    wait_ready();
    w   = int'(addr >> 2);
    sz  = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    bad = we ? f3 > 3'd2 : (f3 == 3'd3 || f3 >= 3'd6);
    err = bad;
`ifdef LSU_MISALIGN_TRAP_EN
    if (int'(addr[1:0]) % sz != 0) err = 1'b1;
`endif
    off = int'(addr[1:0]) / sz * sz;
    old = model_mem.exists(w) ? model_mem[w] : 32'h0;
    nw  = old;
    v   = 32'h0;
    for (int i = 0; i < sz; i++) begin
      v[8*i +: 8]        = old[8*(off+i) +: 8];
      nw[8*(off+i) +: 8] = wd[8*i +: 8];
    end
    if (!f3[2] && sz < 4 && v[8*sz-1]) for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
    e_mask = 4'(((1 << sz) - 1) << off);
    if (err || !we) nw = old;
    e_lat = err ? 1 : (we && sz == 4) ? 2 : 3;
    e_rd  = (err || (we && sz == 4)) ? 0 : 1;
    e_wr  = (!err && we) ? 1 : 0;
    if (!err && !we) model_rdata = v;
    exp_rdata = model_rdata;
    exp_err   = err;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; done = 1'b0; r = 32'h0; re = 1'b0; seen_wd = 32'h0;
    for (int k = 1; k <= 8 && !done; k++) begin
      @(negedge clk);
      if (mem_memread) nrd++;
      if (mem_memwrite) begin nwr++; seen_wd = mem_write_data; end
      if (mem_memread || mem_memwrite) begin
        chk("mem_addr", mem_addr, 32'(w));
        chk("mem_mask", 32'(mem_sign_mask), 32'(e_mask));
      end
      if (resp_valid) begin lat = k; done = 1'b1; r = resp_rdata; re = resp_err; end
    end
    chk("latency", 32'(lat), 32'(e_lat));
    chk("read_strobes", 32'(nrd), 32'(e_rd));
    chk("write_strobes", 32'(nwr), 32'(e_wr));
    if (e_wr != 0) chk("write_word", seen_wd, nw);
    chk("mem_word", mem[w % 16384], nw);
    model_mem[w] = nw;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_valid", 32'(resp_valid), 32'h0);
    chk("rst_err", 32'(resp_err), 32'h0);
    chk("rst_rdata", resp_rdata, RESET_RDATA);
    chk("rst_rd", 32'(mem_memread), 32'h0);
    chk("rst_wr", 32'(mem_memwrite), 32'h0);
    chk("rst_mask", 32'(mem_sign_mask), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    preload(5, 32'h8899AABB);
    preload(3, 32'h11223344);
    preload(0, 32'hCAFEF00D);
    preload(7, 32'hDEADBEEF);
    access(1'b0, 3'b000, 32'h16, 32'h0, got, got_err);
    chk("lb_lit", got, 32'hFFFFFF99);
    access(1'b0, 3'b100, 32'h16, 32'h0, got, got_err);
    chk("lbu_lit", got, 32'h00000099);
    access(1'b0, 3'b001, 32'h16, 32'h0, got, got_err);
    chk("lh_lit", got, 32'hFFFF8899);
    access(1'b0, 3'b101, 32'h14, 32'h0, got, got_err);
    chk("lhu_lit", got, 32'h0000AABB);
    access(1'b0, 3'b010, 32'h14, 32'h0, got, got_err);
    chk("lw_lit", got, 32'h8899AABB);
    access(1'b1, 3'b000, 32'h0D, 32'hFFFFFF5A, got, got_err);
    chk("sb_lit", mem[3], 32'h11225A44);
    access(1'b1, 3'b001, 32'h0E, 32'h1234BEEF, got, got_err);
    chk("sh_lit", mem[3], 32'hBEEF5A44);
    access(1'b0, 3'b000, 32'h0F, 32'h0, got, got_err);
    chk("lb3_lit", got, 32'hFFFFFFBE);
    access(1'b1, 3'b010, 32'h8000, 32'h000000A5, got, got_err);
    chk("sw_lit", mem[32'h2000], 32'h000000A5);
    access(1'b0, 3'b010, 32'h0002, 32'h0, got, got_err);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_err", 32'(got_err), 32'h1);
`else
    chk("lw_mis_lit", got, 32'hCAFEF00D);
`endif
    access(1'b0, 3'b001, 32'h0D, 32'h0, got, got_err);
    access(1'b0, 3'b011, 32'h14, 32'h0, got, got_err);
    chk("ill_load_err", 32'(got_err), 32'h1);
    access(1'b1, 3'b100, 32'h14, 32'h12345678, got, got_err);
    chk("ill_store_err", 32'(got_err), 32'h1);
    access(1'b1, 3'b000, 32'h1F, 32'h000000C3, got, got_err);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h1D; req_wdata = 32'h77;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_read", 32'(mem_memread), 32'h1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_no_write", 32'(mem_memwrite), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    model_rdata = RESET_RDATA;
    @(negedge clk);
    chk("rst_ready_after", 32'(req_ready), 32'h1);
    chk("rst_no_write2", 32'(mem_memwrite), 32'h0);
    chk("rst_no_valid", 32'(resp_valid), 32'h0);
    chk("rst_mem_kept", mem[7], 32'hC3ADBEEF);
    access(1'b0, 3'b010, 32'h1C, 32'h0, got, got_err);
    chk("post_rst_lw", got, 32'hC3ADBEEF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the core's execute stage and data_memory. Converts RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-indexed data_memory accesses.
- Sign/zero-extends load data.
- Performs read-modify-write for sub-word stores; data_memory writes whole 32-bit words only.
- Holds the core off with a ready/valid handshake while an access is in flight.

Parameters:
ADDR_WIDTH, 32, width of core byte address and memory word-index port
RESET_RDATA, 32'h0, value of resp_rdata after reset

Ports:
clk  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  1  core request valid
req_ready  out  1  unit idle, can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle pulse: load data / store ack / error
resp_rdata  out  32  extended load data; holds last value otherwise
resp_err  out  1  valid with resp_valid: misaligned or illegal funct3
mem_addr  out  ADDR_WIDTH  word index = req_addr >> 2, zero-filled
mem_write_data  out  32  full word to write
mem_memwrite  out  1  memory write strobe
mem_memread  out  1  memory read strobe
mem_sign_mask  out  4  byte-lane mask of current access (lane0 = bits 7:0)
mem_read_data  in  32  registered memory output, valid the cycle after mem_memread

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=RESET_RDATA, mem_memwrite=0, mem_memread=0, mem_sign_mask=0, state IDLE.
- Handshake:
  - Accept only when req_valid & req_ready at a posedge; capture we/funct3/addr/wdata.
  - req_ready=1 only in IDLE; requests while busy are ignored, and the core holds them.
- States: IDLE, ISSUE, LOAD_CAP, RMW_MERGE, RESP.
  - IDLE -> ISSUE on accept.
  - IDLE -> RESP directly on an error request (see below).
- ISSUE:
  - Load or sub-word store: mem_memread=1.
  - SW: mem_memwrite=1 with mem_write_data=wdata.
  - Next state: LOAD_CAP for loads, RMW_MERGE for SB/SH, RESP for SW.
- LOAD_CAP:
  - Select byte lane addr[1:0] (B) or half addr[1] (H) from mem_read_data.
  - Sign-extend for B/H, zero-extend for BU/HU, pass word for W.
  - Register the result into resp_rdata. -> RESP.
- RMW_MERGE:
  - mem_memwrite=1, same mem_addr.
  - mem_write_data = mem_read_data with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]. This is a combinational merge path.
  - -> RESP.
- RESP: resp_valid=1 for one cycle. -> IDLE. req_ready returns 1 the following cycle.
- Latency from accept edge to resp_valid: load 3 cycles, SW 2, SB/SH 3, error 1.
- mem_addr, mem_sign_mask: registered at accept, stable for the whole access.
  - Mask values: B 0001<<addr[1:0], H 0011<<(2*addr[1]), W 1111.
- Error requests, which never touch memory:
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - Misalignment is also an error when the feature below is enabled.
  - resp_err=1 with resp_valid; resp_rdata unchanged.
- mem_memread and mem_memwrite are never both 1 in the same cycle.
- Reset mid-operation: return to IDLE next edge; no write strobe after the reset edge. An interrupted RMW may leave a read performed but no write; memory is unchanged.
- Address wrap: mem_addr carries addr[ADDR_WIDTH-1:2]; no range check. MMIO decode, e.g. LED at word 0x2000, belongs to data_memory.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0, produce an error response and no memory access.
- Undefined: the offending low address bits are treated as 0 (force-aligned) and the access proceeds normally with resp_err=0.

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding, lane-mask function.
- One combinational sub-module, lsu_align: load extract/extend and store merge. Reused by LOAD_CAP and RMW_MERGE.

Test Plan:
- Memory word 5 = 32'h8899AABB.
  - LB addr 0x16 -> resp_rdata 32'hFFFFFF99, resp_valid 3 cycles after accept.
  - LBU same address -> 32'h00000099.
- LH addr 0x16 -> 32'hFFFF8899.
- LHU addr 0x14 -> 32'h0000AABB.
- Memory word 3 = 32'h11223344; SB addr 0x0D data 32'hFFFFFF5A.
  - Required: read strobe, then write 32'h11225A44 to mem_addr 3 with mask 0010.
  - Ack on the third cycle.
- SW addr 0x8000 data 32'h000000A5 -> one write to mem_addr 0x2000; ack 2 cycles after accept; no read strobe.
- Misaligned LW addr 0x0002:
  - LSU_MISALIGN_TRAP_EN defined -> resp_err=1 next cycle, no strobes.
  - Undefined -> word 0 returned.
- Illegal funct3 011 load -> resp_err=1 next cycle, no strobes.
- Reset asserted during RMW_MERGE -> no write strobe after the reset edge; memory unchanged; req_ready=1 on the next cycle.
